// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the RV32 subset main control unit
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // State codes kept as plain constants so external tools can match the encoding.
  localparam logic [3:0] ST_START     = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_EXEC_R    = 4'd3;
  localparam logic [3:0] ST_EXEC_I    = 4'd4;
  localparam logic [3:0] ST_ALU_WB    = 4'd5;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd6;
  localparam logic [3:0] ST_MEM_READ  = 4'd7;
  localparam logic [3:0] ST_MEM_WB    = 4'd8;
  localparam logic [3:0] ST_MEM_WRITE = 4'd9;
  localparam logic [3:0] ST_BRANCH    = 4'd10;
  localparam logic [3:0] ST_TRAP      = 4'd11;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_NONE   = 3'd5
  } instr_class_e;

  function automatic logic [3:0] pack_funct(input logic f7_bit5, input logic [2:0] funct3);
    return {f7_bit5, funct3};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - instruction class, legality and Funct from the IR
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0]  ir_i,
  output instr_class_e cls_o,
  output logic         legal_o,
  output logic [3:0]   funct_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir_bits;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign funct7 = ir_i[31:25];
  // Register and immediate fields play no part in control decisions.
  assign unused_ir_bits = ^{ir_i[24:15], ir_i[11:7]};

  always_comb begin
    cls_o   = CLS_NONE;
    legal_o = 1'b0;
    funct_o = 4'b0000;
    case (opcode)
      OP_R: begin
        cls_o   = CLS_R;
        legal_o = ((funct7 == F7_BASE) && (funct3 inside {F3_ADD, F3_AND, F3_OR}))
                || ((funct7 == F7_ALT) && (funct3 == F3_ADD));
        funct_o = pack_funct(funct7[5], funct3);
      end
      OP_I: begin
        cls_o   = CLS_I;
        legal_o = funct3 inside {F3_ADD, F3_AND, F3_OR};
        funct_o = pack_funct(1'b0, funct3);
      end
      OP_LOAD: begin
        cls_o   = CLS_LOAD;
        legal_o = (funct3 == F3_LW);
      end
      OP_STORE: begin
        cls_o   = CLS_STORE;
        legal_o = (funct3 == F3_LW);
      end
      OP_BRANCH: begin
        cls_o   = CLS_BRANCH;
        legal_o = funct3 inside {F3_BEQ, F3_BLT};
        funct_o = pack_funct(1'b0, funct3);
      end
      default: begin
        cls_o   = CLS_NONE;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle fetch/decode/execute sequencer with Moore strobes
module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_branch,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_b,
  output logic [1:0]  ALUOp,
  output logic [3:0]  Funct,
  output logic [31:0] instr,
  output logic        illegal
);

  localparam logic [7:0] HOLD_CYCLES = 8'(RESET_PC_HOLD);

  logic [3:0]   state_q, state_d;
  logic [31:0]  ir_q, ir_d;
  logic [7:0]   hold_q, hold_d;
  instr_class_e dec_cls;
  logic         dec_legal;
  logic [3:0]   dec_funct;
  logic [2:0]   funct3;

  assign funct3 = ir_q[14:12];
  assign instr  = ir_q;

  ctrl_decode u_decode (
    .ir_i   (ir_q),
    .cls_o  (dec_cls),
    .legal_o(dec_legal),
    .funct_o(dec_funct)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    hold_d  = hold_q;
    case (state_q)
      ST_START: begin
        if (hold_q == HOLD_CYCLES) state_d = ST_FETCH;
        else                       hold_d  = hold_q + 8'd1;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
          ir_d    = mem_rdata;
        end
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          state_d = ST_TRAP;
        end else begin
          case (dec_cls)
            CLS_R:                state_d = ST_EXEC_R;
            CLS_I:                state_d = ST_EXEC_I;
            CLS_LOAD, CLS_STORE:  state_d = ST_MEM_ADDR;
            CLS_BRANCH:           state_d = ST_BRANCH;
            default:              state_d = ST_TRAP;
          endcase
        end
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_ALU_WB:            state_d = ST_FETCH;
      ST_MEM_ADDR:          state_d = (dec_cls == CLS_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:          if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE:         if (mem_ready) state_d = ST_FETCH;
      ST_MEM_WB:            state_d = ST_FETCH;
      ST_BRANCH:            state_d = ST_FETCH;
      ST_TRAP:              state_d = ST_TRAP;
      // Unreachable encodings are treated as a trap rather than silently re-fetching.
      default:              state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_START;
      ir_q    <= 32'h0;
      hold_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    ALUOp      = ALUOP_ADD;
    Funct      = 4'b0000;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_EXEC_R: begin
        ALUOp = ALUOP_FUNCT;
        Funct = dec_funct;
      end
      ST_EXEC_I: begin
        ALUOp     = ALUOP_FUNCT;
        Funct     = dec_funct;
        alu_src_b = 1'b1;
      end
      ST_ALU_WB: begin
        ALUOp     = ALUOP_FUNCT;
        Funct     = dec_funct;
        reg_write = 1'b1;
      end
      ST_MEM_ADDR: begin
        ALUOp     = ALUOP_ADD;
        alu_src_b = 1'b1;
      end
      ST_MEM_READ: mem_req = 1'b1;
      ST_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        ALUOp     = ALUOP_BR;
        Funct     = dec_funct;
        pc_branch = ((funct3 == F3_BEQ) && alu_zero) || ((funct3 == F3_BLT) && alu_lt);
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - table-driven scoreboard bench for main_control_fsm
module tb_main_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_rdata;
  logic        mem_ready, alu_zero, alu_lt;
  logic        mem_req, mem_we, ir_write, pc_write, pc_branch, reg_write, mem_to_reg, alu_src_b;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic [31:0] instr;
  logic        illegal;

  main_control_fsm #(.RESET_PC_HOLD(0)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .Funct(Funct), .instr(instr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          dw;
    logic        zero;
    logic        lt;
    int          cycles;
    int          req;
    int          we;
    int          rw;
    logic        m2r;
    int          br;
    logic [3:0]  funct;
    logic [1:0]  aluop;
    int          srcb;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    int          req;
    int          we;
    int          rw;
    logic        m2r;
    int          br;
    logic [3:0]  funct;
    logic [1:0]  aluop;
    int          srcb;
    int          irw_at;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_outs"}, {17'h0, mem_req, mem_we, ir_write, pc_write, pc_branch, reg_write,
                          mem_to_reg, alu_src_b, ALUOp, Funct, illegal}, 32'h0);
    chk({name, "_instr"}, instr, 32'h0);
  endtask

  // Called with reset high; FETCH must appear on the second cycle after release.
  task automatic release_reset(input string name);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_all_zero({name, "_start"});
    @(negedge clk);
    #1;
    chk({name, "_fetch_req"}, mem_req, 1);
  endtask

  // Starts in FETCH; ends sampling the following FETCH cycle.
  task automatic run_one(input vec_t v, input int idx);
    exp_t e;
    int n_req = 0, n_we = 0, n_rw = 0, n_br = 0, n_srcb = 0, n_irw = 0, n_pw = 0, n_ill = 0;
    int irw_at = -1;
    logic m2r = 1'b0;
    logic end_ok = 1'b0;
    logic [3:0] fo = 4'h0;
    logic [1:0] ao = 2'b00;
    logic [31:0] ins_end = 32'h0;
    e = '{v.ins, v.req, v.we, v.rw, v.m2r, v.br, v.funct, v.aluop, v.srcb, v.fw};
    sb_q.push_back(e);
    alu_zero = v.zero;
    alu_lt   = v.lt;
    for (int c = 0; c <= v.cycles; c++) begin
      mem_rdata = (c == v.fw) ? v.ins : 32'hDEAD_BEEF;
      mem_ready = !((c < v.fw) || (c >= v.fw + 3 && c < v.fw + 3 + v.dw) || (c == v.cycles));
      #1;
      if (c < v.cycles) begin
        if (mem_req)   n_req++;
        if (mem_we)    n_we++;
        if (reg_write) n_rw++;
        if (pc_branch) n_br++;
        if (alu_src_b) n_srcb++;
        if (pc_write)  n_pw++;
        if (illegal)   n_ill++;
        if (ir_write) begin
          n_irw++;
          irw_at = c;
        end
        m2r = m2r | mem_to_reg;
        fo  = fo | Funct;
        ao  = ao | ALUOp;
        @(negedge clk);
      end else begin
        end_ok  = mem_req && !mem_we && !ir_write;
        ins_end = instr;
      end
    end
    e = sb_q.pop_front();
    chk($sformatf("v%0d_req", idx),    n_req,  e.req);
    chk($sformatf("v%0d_we", idx),     n_we,   e.we);
    chk($sformatf("v%0d_rw", idx),     n_rw,   e.rw);
    chk($sformatf("v%0d_m2r", idx),    m2r,    e.m2r);
    chk($sformatf("v%0d_br", idx),     n_br,   e.br);
    chk($sformatf("v%0d_funct", idx),  fo,     e.funct);
    chk($sformatf("v%0d_aluop", idx),  ao,     e.aluop);
    chk($sformatf("v%0d_srcb", idx),   n_srcb, e.srcb);
    chk($sformatf("v%0d_irw", idx),    n_irw,  1);
    chk($sformatf("v%0d_irw_at", idx), irw_at, e.irw_at);
    chk($sformatf("v%0d_pw", idx),     n_pw,   1);
    chk($sformatf("v%0d_ill", idx),    n_ill,  0);
    chk($sformatf("v%0d_end", idx),    end_ok, 1);
    chk($sformatf("v%0d_instr", idx),  ins_end, e.ins);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] traps [3];
    int bad;

    //          ins           fw dw z     l     cyc req we rw m2r   br funct    aluop  srcb
    vecs[0]  = '{32'h002081B3, 0, 0, 1'b0, 1'b0, 4, 1, 0, 1, 1'b0, 0, 4'b0000, 2'b10, 0};
    vecs[1]  = '{32'h402081B3, 3, 0, 1'b0, 1'b0, 7, 4, 0, 1, 1'b0, 0, 4'b1000, 2'b10, 0};
    vecs[2]  = '{32'h00507093, 1, 0, 1'b0, 1'b0, 5, 2, 0, 1, 1'b0, 0, 4'b0111, 2'b10, 1};
    vecs[3]  = '{32'h0020E1B3, 0, 0, 1'b0, 1'b0, 4, 1, 0, 1, 1'b0, 0, 4'b0110, 2'b10, 0};
    vecs[4]  = '{32'h00812283, 0, 0, 1'b0, 1'b0, 5, 2, 0, 1, 1'b1, 0, 4'b0000, 2'b00, 1};
    vecs[5]  = '{32'h00812283, 1, 2, 1'b0, 1'b0, 8, 5, 0, 1, 1'b1, 0, 4'b0000, 2'b00, 1};
    vecs[6]  = '{32'h00512623, 0, 0, 1'b0, 1'b0, 4, 2, 1, 0, 1'b0, 0, 4'b0000, 2'b00, 1};
    vecs[7]  = '{32'h00512623, 2, 1, 1'b0, 1'b0, 7, 5, 2, 0, 1'b0, 0, 4'b0000, 2'b00, 1};
    vecs[8]  = '{32'h00208463, 0, 0, 1'b1, 1'b0, 3, 1, 0, 0, 1'b0, 1, 4'b0000, 2'b01, 0};
    vecs[9]  = '{32'h00208463, 0, 0, 1'b0, 1'b1, 3, 1, 0, 0, 1'b0, 0, 4'b0000, 2'b01, 0};
    vecs[10] = '{32'h0020C463, 0, 0, 1'b1, 1'b0, 3, 1, 0, 0, 1'b0, 0, 4'b0100, 2'b01, 0};
    vecs[11] = '{32'h0020C463, 1, 0, 1'b0, 1'b1, 4, 2, 0, 0, 1'b0, 1, 4'b0100, 2'b01, 0};
    vecs[12] = '{32'h00500093, 0, 0, 1'b0, 1'b0, 4, 1, 0, 1, 1'b0, 0, 4'b0000, 2'b10, 1};
    traps[0] = 32'h0000007F;
    traps[1] = 32'h00109093;
    traps[2] = 32'h0020B4B3;

    reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    alu_zero = 1'b0;
    alu_lt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    release_reset("rst0");

    for (int i = 0; i < 13; i++) run_one(vecs[i], i);

    for (int t = 0; t < 3; t++) begin
      mem_rdata = traps[t];
      mem_ready = 1'b1;
      @(negedge clk);
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      #1;
      chk($sformatf("trap%0d_illegal", t), illegal, 1);
      bad = 0;
      repeat (8) begin
        @(negedge clk);
        #1;
        if (mem_req || reg_write || pc_write || ir_write || pc_branch || !illegal) bad++;
      end
      chk($sformatf("trap%0d_sticky", t), bad, 0);
      chk($sformatf("trap%0d_instr", t), instr, traps[t]);
      reset = 1'b1;
      #1;
      check_all_zero($sformatf("trap%0d_rst", t));
      release_reset($sformatf("trap%0d_rel", t));
    end

    // Abort a load while it waits in MEM_READ.
    mem_rdata = 32'h00812283;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("abort_pre_req", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    release_reset("abort_rel");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
